// File: rtl/cut_pkg.sv
// Shared definitions for the cut stroke sequencer.
//   state_e : sequencer FSM states (3-bit encoding, codes 7 unused)
//   DIR_CW / DIR_CCW : motor direction levels presented on direction_o
package cut_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FWD   = 3'd1,
    DEAD1 = 3'd2,
    REV   = 3'd3,
    DEAD2 = 3'd4,
    DONE  = 3'd5,
    FAULT = 3'd6
  } state_e;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

endpackage

// File: rtl/cut_sequencer_if.sv
// Signal bundle between the main controller / cutter hardware and the
// cut sequencer.
//   Controller side (master) drives: cut_req_i, cut_abort_i, home_i, fault_clr_i
//   Sequencer side  (slave)  drives: busy_o, cut_done_o, aborted_o, fault_o,
//                                    en_o, direction_o
interface cut_sequencer_if;

  logic cut_req_i;
  logic cut_abort_i;
  logic home_i;
  logic fault_clr_i;
  logic busy_o;
  logic cut_done_o;
  logic aborted_o;
  logic fault_o;
  logic en_o;
  logic direction_o;

  modport master (
    output cut_req_i, cut_abort_i, home_i, fault_clr_i,
    input  busy_o, cut_done_o, aborted_o, fault_o, en_o, direction_o
  );

  modport slave (
    input  cut_req_i, cut_abort_i, home_i, fault_clr_i,
    output busy_o, cut_done_o, aborted_o, fault_o, en_o, direction_o
  );

endinterface

// File: rtl/ms_timer.sv
// Millisecond down-timer used to time each sequencer state.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : reload prescaler and ms counter (state entry)
//   load_val   : duration in ms to time from the load
//   expired    : high on the last clock cycle of the loaded duration
module ms_timer #(
  parameter int CYC_PER_MS = 10,
  parameter int TMR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             expired
);

  localparam int PW = $clog2(CYC_PER_MS);
  localparam logic [PW-1:0] PRESC_TOP = PW'(CYC_PER_MS - 1);

  logic [PW-1:0]    presc_r;
  logic [TMR_W-1:0] ms_r;

  // Counters hold "remaining minus one", so the all-zero point is the final cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= PW'(0);
      ms_r    <= TMR_W'(0);
    end else if (load) begin
      presc_r <= PRESC_TOP;
      ms_r    <= (load_val == TMR_W'(0)) ? TMR_W'(0) : (load_val - TMR_W'(1));
    end else if (presc_r == PW'(0)) begin
      presc_r <= PRESC_TOP;
      if (ms_r != TMR_W'(0)) begin
        ms_r <= ms_r - TMR_W'(1);
      end
    end else begin
      presc_r <= presc_r - PW'(1);
    end
  end

  assign expired = (presc_r == PW'(0)) && (ms_r == TMR_W'(0));

endmodule

// File: rtl/cut_sequencer.sv
// Cut stroke sequencer: forward stroke, dead time, reverse to home,
// dead time, then completion handshake. Handles abort, return timeout
// and fault latching.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cut_sequencer_if.slave (request/abort/home/fault clear in,
//                busy/done/aborted/fault/motor enable/direction out)
// All outputs are decoded from the registered state only.
module cut_sequencer
  import cut_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int STROKE_MS   = 300,
  parameter int DEAD_MS     = 20,
  parameter int RETURN_MS   = 600,
  parameter int TMR_W       = 16
) (
  input logic            clk,
  input logic            rst_n,
  cut_sequencer_if.slave bus
);

  localparam int CYC_PER_MS = CLK_FREQ_HZ / 1000;

  state_e           state_r;
  state_e           next_state_s;
  logic [1:0]       home_sync_r;
  logic             home_s;
  logic             aborted_r;
  logic             tmr_load_s;
  logic [TMR_W-1:0] tmr_val_s;
  logic             tmr_expired_s;
  logic             busy_s;
  logic             done_s;
  logic             aborted_s;
  logic             fault_s;
  logic             en_s;
  logic             dir_s;

  // Two-flop synchronizer for the asynchronous home limit switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      home_sync_r <= 2'b00;
    end else begin
      home_sync_r <= {home_sync_r[0], bus.home_i};
    end
  end

  assign home_s = home_sync_r[1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic. Abort beats stroke expiry; home beats return timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (bus.cut_req_i) next_state_s = FWD; else next_state_s = IDLE;
      FWD:     if (bus.cut_abort_i || tmr_expired_s) next_state_s = DEAD1;
               else next_state_s = FWD;
      DEAD1:   if (tmr_expired_s) next_state_s = REV; else next_state_s = DEAD1;
      REV:     if (home_s) next_state_s = DEAD2;
               else if (tmr_expired_s) next_state_s = FAULT;
               else next_state_s = REV;
      DEAD2:   if (tmr_expired_s) next_state_s = DONE; else next_state_s = DEAD2;
      DONE:    if (!bus.cut_req_i) next_state_s = IDLE; else next_state_s = DONE;
      FAULT:   if (bus.fault_clr_i && !bus.cut_req_i) next_state_s = IDLE;
               else next_state_s = FAULT;
      default: next_state_s = IDLE;
    endcase
  end

  // Abort flag: set by an abort during the forward stroke, cleared on return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted_r <= 1'b0;
    end else if ((state_r == FWD) && bus.cut_abort_i) begin
      aborted_r <= 1'b1;
    end else if ((state_r != IDLE) && (next_state_s == IDLE)) begin
      aborted_r <= 1'b0;
    end else begin
      aborted_r <= aborted_r;
    end
  end

  // Timer reload on every state change, with the duration of the state being entered.
  always_comb begin
    tmr_load_s = (next_state_s != state_r);
    case (next_state_s)
      FWD:          tmr_val_s = TMR_W'(STROKE_MS);
      DEAD1, DEAD2: tmr_val_s = TMR_W'(DEAD_MS);
      REV:          tmr_val_s = TMR_W'(RETURN_MS);
      default:      tmr_val_s = TMR_W'(0);
    endcase
  end

  ms_timer #(
    .CYC_PER_MS (CYC_PER_MS),
    .TMR_W      (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .expired  (tmr_expired_s)
  );

  // Moore output decode.
  always_comb begin
    busy_s    = 1'b0;
    done_s    = 1'b0;
    aborted_s = 1'b0;
    fault_s   = 1'b0;
    en_s      = 1'b0;
    dir_s     = DIR_CW;
    case (state_r)
      FWD:          begin busy_s = 1'b1; en_s = 1'b1; dir_s = DIR_CW; end
      DEAD1, DEAD2: begin busy_s = 1'b1; end
      REV:          begin busy_s = 1'b1; en_s = 1'b1; dir_s = DIR_CCW; end
      DONE:         begin busy_s = 1'b1; done_s = 1'b1; aborted_s = aborted_r; end
      FAULT:        begin fault_s = 1'b1; end
      default:      begin busy_s = 1'b0; end
    endcase
  end

  assign bus.busy_o      = busy_s;
  assign bus.cut_done_o  = done_s;
  assign bus.aborted_o   = aborted_s;
  assign bus.fault_o     = fault_s;
  assign bus.en_o        = en_s;
  assign bus.direction_o = dir_s;

endmodule

// File: tb/tb_cut_sequencer.sv
// Scoreboard bench for cut_sequencer. Stimulus pushes the expected sequence
// of output segments (output code + duration in cycles, 0 = any length);
// a negedge monitor closes a segment whenever the output code changes and
// compares it against the head of the queue.
// Output code = {busy, en, dir, done, aborted, fault}.
module tb_cut_sequencer;

  localparam logic [5:0] C_IDLE  = 6'b000000;
  localparam logic [5:0] C_FWD   = 6'b110000;
  localparam logic [5:0] C_DEAD  = 6'b100000;
  localparam logic [5:0] C_REV   = 6'b111000;
  localparam logic [5:0] C_DONE  = 6'b100100;
  localparam logic [5:0] C_DONEA = 6'b100110;
  localparam logic [5:0] C_FAULT = 6'b000001;

  typedef struct {
    logic [5:0] code;
    int         len;
    string      name;
  } seg_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  seg_t exp_q[$];

  cut_sequencer_if bus ();

  cut_sequencer #(
    .CLK_FREQ_HZ (10000),
    .STROKE_MS   (3),
    .DEAD_MS     (1),
    .RETURN_MS   (5),
    .TMR_W       (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] out_code();
    return {bus.busy_o, bus.en_o, bus.direction_o, bus.cut_done_o, bus.aborted_o, bus.fault_o};
  endfunction

  task automatic push(input logic [5:0] c, input int l, input string n);
    seg_t s;
    s.code = c;
    s.len  = l;
    s.name = n;
    exp_q.push_back(s);
  endtask

  // Monitor: segment tracking and scoreboard compare
  logic [5:0] cur_code = 6'b000000;
  int         cur_len = 0;
  logic       prev_en = 1'b0;
  logic       prev_dir = 1'b0;
  int         dir_glitch = 0;
  seg_t       mon_s;
  logic [5:0] mon_c;

  always @(negedge clk) begin
    mon_c = out_code();
    if (prev_en && bus.en_o && (prev_dir !== bus.direction_o)) dir_glitch++;
    prev_en  = bus.en_o;
    prev_dir = bus.direction_o;
    if (mon_c !== cur_code) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL seg_unexpected: got code=%b len=%0d, expected no further segment", cur_code, cur_len);
      end else begin
        mon_s = exp_q.pop_front();
        if ((mon_s.code !== cur_code) || ((mon_s.len != 0) && (mon_s.len != cur_len))) begin
          errors++;
          $display("FAIL %s: got code=%b len=%0d, expected code=%b len=%0d",
                   mon_s.name, cur_code, cur_len, mon_s.code, mon_s.len);
        end
      end
      cur_code = mon_c;
      cur_len  = 1;
    end else begin
      cur_len++;
    end
  end

  task automatic check_now(input string n, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", n, got, exp);
    end
  endtask

  // sel: 0 = REV, 1 = DONE, 2 = FAULT, 3 = FWD
  task automatic wait_for(input int sel, input string n);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0: hit = bus.en_o && bus.direction_o;
        1: hit = bus.cut_done_o;
        2: hit = bus.fault_o;
        default: hit = bus.en_o && !bus.direction_o;
      endcase
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got no event in 1000 cycles, expected event", n);
    end
  endtask

  task automatic start_req();
    @(posedge clk);
    #1 bus.cut_req_i = 1'b1;
  endtask

  // Home rises d cycles into REV; REV then lasts d+3 cycles.
  task automatic rev_home(input int d);
    wait_for(0, "rev");
    repeat (d) @(posedge clk);
    #1 bus.home_i = 1'b1;
  endtask

  task automatic finish_done();
    wait_for(1, "done");
    @(posedge clk);
    #1 bus.cut_req_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.home_i = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    bus.cut_req_i   = 1'b0;
    bus.cut_abort_i = 1'b0;
    bus.home_i      = 1'b0;
    bus.fault_clr_i = 1'b0;
    push(C_IDLE, 0, "reset_idle");
    #1 check_now("reset_outputs", out_code(), C_IDLE);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 1: nominal cut
    push(C_FWD, 30, "s1_fwd");   push(C_DEAD, 10, "s1_dead1");
    push(C_REV, 18, "s1_rev");   push(C_DEAD, 10, "s1_dead2");
    push(C_DONE, 2, "s1_done");  push(C_IDLE, 0, "s1_idle");
    start_req();
    rev_home(15);
    finish_done();

    // 2: abort in cycle 12 of the forward stroke
    push(C_FWD, 13, "s2_fwd");   push(C_DEAD, 10, "s2_dead1");
    push(C_REV, 8, "s2_rev");    push(C_DEAD, 10, "s2_dead2");
    push(C_DONEA, 2, "s2_done"); push(C_IDLE, 0, "s2_idle");
    start_req();
    wait_for(3, "fwd");
    repeat (12) @(posedge clk);
    #1 bus.cut_abort_i = 1'b1;
    @(posedge clk);
    #1 bus.cut_abort_i = 1'b0;
    rev_home(5);
    finish_done();

    // 3: return timeout, fault clear blocked while req high
    push(C_FWD, 30, "s3_fwd");   push(C_DEAD, 10, "s3_dead1");
    push(C_REV, 50, "s3_rev");   push(C_FAULT, 7, "s3_fault");
    push(C_IDLE, 0, "s3_idle");
    start_req();
    wait_for(2, "fault");
    @(posedge clk);
    #1 bus.fault_clr_i = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus.cut_req_i = 1'b0;
    @(posedge clk);
    #1 bus.fault_clr_i = 1'b0;
    repeat (5) @(posedge clk);

    // 4: home already high on REV entry
    #1 bus.home_i = 1'b1;
    repeat (4) @(posedge clk);
    push(C_FWD, 30, "s4_fwd");   push(C_DEAD, 10, "s4_dead1");
    push(C_REV, 1, "s4_rev");    push(C_DEAD, 10, "s4_dead2");
    push(C_DONE, 2, "s4_done");  push(C_IDLE, 0, "s4_idle");
    start_req();
    finish_done();

    // 5 + 6: reset mid-REV, restart, then request held through DONE
    push(C_FWD, 30, "s5_fwd");   push(C_DEAD, 10, "s5_dead1");
    push(C_REV, 5, "s5_rev");    push(C_IDLE, 4, "s5_reset");
    push(C_FWD, 30, "s5_fwd2");  push(C_DEAD, 10, "s5_dead1b");
    push(C_REV, 5, "s5_rev2");   push(C_DEAD, 10, "s5_dead2");
    push(C_DONE, 101, "s6_done_held"); push(C_IDLE, 0, "s6_idle");
    start_req();
    wait_for(0, "rev_pre_reset");
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_now("async_reset_drop", out_code(), C_IDLE);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rev_home(2);
    wait_for(1, "done_held");
    repeat (100) @(posedge clk);
    #1 bus.cut_req_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.home_i = 1'b0;
    repeat (5) @(posedge clk);

    checks++;
    if (dir_glitch != 0) begin
      errors++;
      $display("FAIL dir_while_enabled: got %0d toggles, expected 0", dir_glitch);
    end
    checks++;
    if ((exp_q.size() != 1) || (exp_q[0].code !== cur_code)) begin
      errors++;
      $display("FAIL final_segment: got %0d pending, code=%b, expected 1 pending, code=%b",
               exp_q.size(), cur_code, C_IDLE);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
